// File: rtl/i2c_reg_slave_pkg.sv
// rtl/i2c_reg_slave_pkg.sv - shared state encodings and I2C direction bits for the config bus
package i2c_reg_slave_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_SUB      = 3'd3;
  localparam logic [2:0] ST_SUB_ACK  = 3'd4;
  localparam logic [2:0] ST_DATA     = 3'd5;
  localparam logic [2:0] ST_DATA_ACK = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  // True when an address byte selects ownAddr for a write; reads are never claimed
  function automatic logic isOwnWrite(input logic [7:0] addrByte, input logic [6:0] ownAddr);
    return (addrByte[7:1] == ownAddr) && (addrByte[0] == I2C_WR);
  endfunction

endpackage

// File: rtl/i2c_reg_slave_if.sv
// rtl/i2c_reg_slave_if.sv - register-write port of the I2C config target
interface i2c_reg_slave_if;
  logic [7:0] oREG_ADDR;
  logic [7:0] oREG_DATA;
  logic       oREG_WE;
  logic       oBUSY;

  modport slave  (output oREG_ADDR, output oREG_DATA, output oREG_WE, output oBUSY);
  modport master (input  oREG_ADDR, input  oREG_DATA, input  oREG_WE, input  oBUSY);
endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer, run-length glitch filter and edge detect for one I2C line
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iLINE,
  output logic oLEVEL,
  output logic oRISE,
  output logic oFALL
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    syncReg;
  logic [CW-1:0] runCnt;
  logic          levelDly;

  // Two-flop synchronizer; idle bus level is high
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) syncReg <= 2'b11;
    else         syncReg <= {syncReg[0], iLINE};
  end

  // Accept a new level only after FILT_LEN consecutive samples disagree with the current one
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oLEVEL <= 1'b1;
      runCnt <= '0;
    end else if (syncReg[1] == oLEVEL) begin
      runCnt <= '0;
    end else if (runCnt == CW'(FILT_LEN - 1)) begin
      oLEVEL <= syncReg[1];
      runCnt <= '0;
    end else begin
      runCnt <= runCnt + 1'b1;
    end
  end

  // Delayed copy of the filtered level for edge detection
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) levelDly <= 1'b1;
    else         levelDly <= oLEVEL;
  end

  assign oRISE = oLEVEL & ~levelDly;
  assign oFALL = ~oLEVEL & levelDly;

endmodule

// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - I2C write-only register target: {addr+W, sub-addr, data...} to write strobes
module i2c_reg_slave
  import i2c_reg_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         FILT_LEN   = 3
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            I2C_SCLK,
  inout  wire             I2C_SDAT,
  i2c_reg_slave_if.slave  regIf
);

  logic sclLvl, sclRise, sclFall;
  logic sdaLvl, sdaRise, sdaFall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) uSclFilt (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLINE(I2C_SCLK),
    .oLEVEL(sclLvl), .oRISE(sclRise), .oFALL(sclFall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) uSdaFilt (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLINE(I2C_SDAT),
    .oLEVEL(sdaLvl), .oRISE(sdaRise), .oFALL(sdaFall)
  );

  logic [2:0] state;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic [7:0] addrPtr;
  logic       sdaOe;

  // An SDA edge only counts as START/STOP if SCL is steadily high in that same sample
  logic sclSteadyHigh, startDet, stopDet;
  assign sclSteadyHigh = sclLvl & ~sclRise & ~sclFall;
  assign startDet      = sdaFall & sclSteadyHigh;
  assign stopDet       = sdaRise & sclSteadyHigh;

  logic [7:0] byteIn;
  logic       inByte, inAck, byteDone;
  assign byteIn   = {shiftReg[6:0], sdaLvl};
  assign inByte   = (state == ST_ADDR) || (state == ST_SUB) || (state == ST_DATA);
  assign inAck    = (state == ST_ADDR_ACK) || (state == ST_SUB_ACK) || (state == ST_DATA_ACK);
  assign byteDone = sclRise && (bitCnt == 3'd7);

  // Open-drain: pull low only while owing an ACK; a bus condition releases immediately
  assign I2C_SDAT = (sdaOe && !startDet && !stopDet) ? 1'b0 : 1'bz;

  // Protocol FSM: byte assembly, ACK drive across the 9th clock, write strobe generation
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state           <= ST_IDLE;
      bitCnt          <= 3'd0;
      shiftReg        <= 8'h00;
      addrPtr         <= 8'h00;
      sdaOe           <= 1'b0;
      regIf.oREG_ADDR <= 8'h00;
      regIf.oREG_DATA <= 8'h00;
      regIf.oREG_WE   <= 1'b0;
      regIf.oBUSY     <= 1'b0;
    end else begin
      regIf.oREG_WE <= 1'b0;
      if (startDet) begin
        state       <= ST_ADDR;
        bitCnt      <= 3'd0;
        sdaOe       <= 1'b0;
        regIf.oBUSY <= 1'b1;
      end else if (stopDet) begin
        state       <= ST_IDLE;
        bitCnt      <= 3'd0;
        sdaOe       <= 1'b0;
        regIf.oBUSY <= 1'b0;
      end else if (inByte && sclRise) begin
        shiftReg <= byteIn;
        bitCnt   <= byteDone ? 3'd0 : bitCnt + 3'd1;
        if (byteDone) begin
          case (state)
            ST_ADDR: state <= isOwnWrite(byteIn, SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            ST_SUB: begin
              state   <= ST_SUB_ACK;
              addrPtr <= byteIn;
            end
            default: begin
              state           <= ST_DATA_ACK;
              regIf.oREG_DATA <= byteIn;
              regIf.oREG_ADDR <= addrPtr;
            end
          endcase
        end
      end else if (inAck && sclFall) begin
        if (!sdaOe) begin
          // First fall after the 8th bit: start the ACK
          sdaOe <= 1'b1;
          if (state == ST_DATA_ACK) regIf.oREG_WE <= 1'b1;
        end else begin
          // End of the 9th clock: release and move on to the next byte
          sdaOe  <= 1'b0;
          bitCnt <= 3'd0;
          case (state)
            ST_ADDR_ACK: state <= ST_SUB;
            ST_SUB_ACK:  state <= ST_DATA;
            default: begin
              state   <= ST_DATA;
              addrPtr <= addrPtr + 8'd1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - directed bench for i2c_reg_slave driving a bit-banged I2C master
module tb_i2c_reg_slave;

  localparam int Q = 16;

  logic clk = 1'b0;
  logic rstN;
  logic scl;
  logic sdaLow;
  wire  sdaLine;

  assign sdaLine = sdaLow ? 1'b0 : 1'bz;
  pullup (sdaLine);

  i2c_reg_slave_if regIf ();

  i2c_reg_slave #(.SLAVE_ADDR(7'h1A), .FILT_LEN(3)) dut (
    .iCLK(clk),
    .iRST_N(rstN),
    .I2C_SCLK(scl),
    .I2C_SDAT(sdaLine),
    .regIf(regIf)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int driveCnt = 0;
  logic [15:0] weLog[$];

  // Log every cycle the strobe is high, and every cycle the target holds SDA low
  always @(negedge clk) begin
    if (regIf.oREG_WE) weLog.push_back({regIf.oREG_ADDR, regIf.oREG_DATA});
    if (rstN && sdaLine === 1'b0 && !sdaLow) driveCnt = driveCnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2cStart();
    sdaLow = 1'b0; wq(Q);
    scl = 1'b1;    wq(Q);
    sdaLow = 1'b1; wq(Q);
    scl = 1'b0;    wq(Q);
  endtask

  task automatic i2cStop();
    sdaLow = 1'b1; wq(Q);
    scl = 1'b1;    wq(Q);
    sdaLow = 1'b0; wq(Q);
  endtask

  task automatic sendBit(input logic b);
    sdaLow = ~b; wq(Q);
    scl = 1'b1;  wq(2 * Q);
    scl = 1'b0;  wq(Q);
  endtask

  task automatic sclGlitch();
    scl = 1'b1; wq(2);
    scl = 1'b0; wq(Q);
  endtask

  task automatic ackSlot(output logic acked);
    sdaLow = 1'b0; wq(Q);
    scl = 1'b1;    wq(Q);
    acked = (sdaLine === 1'b0);
    wq(Q);
    scl = 1'b0;    wq(Q);
  endtask

  task automatic sendByte(input logic [7:0] b, input int glitchAt, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sendBit(b[i]);
      if (i == glitchAt) sclGlitch();
    end
    ackSlot(acked);
  endtask

  task automatic expStrobe(input string tag, input int idx, input logic [15:0] val);
    chk(tag, (idx < weLog.size()) ? {16'h0, weLog[idx]} : 32'hFFFF_FFFF, {16'h0, val});
  endtask

  logic ack;
  int   base;
  int   d0;
  bit   seen;

  initial begin
    rstN = 1'b0; scl = 1'b1; sdaLow = 1'b0;
    wq(4);
    chk("rst addr", regIf.oREG_ADDR, 8'h00);
    chk("rst data", regIf.oREG_DATA, 8'h00);
    chk("rst we", regIf.oREG_WE, 1'b0);
    chk("rst busy", regIf.oBUSY, 1'b0);
    chk("rst sda", sdaLine, 1'b1);
    rstN = 1'b1;
    wq(4);

    // 1: single write
    base = weLog.size();
    i2cStart();
    chk("t1 busy start", regIf.oBUSY, 1'b1);
    sendByte(8'h34, -1, ack); chk("t1 ack addr", ack, 1'b1);
    sendByte(8'h0E, -1, ack); chk("t1 ack sub", ack, 1'b1);
    sendByte(8'h01, -1, ack); chk("t1 ack data", ack, 1'b1);
    chk("t1 busy mid", regIf.oBUSY, 1'b1);
    i2cStop();
    chk("t1 busy stop", regIf.oBUSY, 1'b0);
    chk("t1 nstrobe", weLog.size() - base, 1);
    expStrobe("t1 strobe", base, 16'h0E01);

    // 2: foreign address is never acknowledged
    base = weLog.size(); d0 = driveCnt;
    i2cStart();
    sendByte(8'h40, -1, ack); chk("t2 ack addr", ack, 1'b0);
    sendByte(8'h12, -1, ack); chk("t2 ack b1", ack, 1'b0);
    sendByte(8'h34, -1, ack); chk("t2 ack b2", ack, 1'b0);
    i2cStop();
    chk("t2 drove", driveCnt - d0, 0);
    chk("t2 nstrobe", weLog.size() - base, 0);

    // 3: read request NACKed, following write works
    base = weLog.size();
    i2cStart();
    sendByte(8'h35, -1, ack); chk("t3 ack rd", ack, 1'b0);
    i2cStop();
    chk("t3 nstrobe rd", weLog.size() - base, 0);
    i2cStart();
    sendByte(8'h34, -1, ack); chk("t3 ack addr", ack, 1'b1);
    sendByte(8'h41, -1, ack);
    sendByte(8'h42, -1, ack); chk("t3 ack data", ack, 1'b1);
    i2cStop();
    chk("t3 nstrobe", weLog.size() - base, 1);
    expStrobe("t3 strobe", base, 16'h4142);

    // 4: burst with pointer increment and wrap
    base = weLog.size();
    i2cStart();
    sendByte(8'h34, -1, ack);
    sendByte(8'h10, -1, ack);
    sendByte(8'hAA, -1, ack);
    sendByte(8'hBB, -1, ack);
    sendByte(8'hCC, -1, ack); chk("t4 ack last", ack, 1'b1);
    i2cStop();
    chk("t4 nstrobe", weLog.size() - base, 3);
    expStrobe("t4 s0", base, 16'h10AA);
    expStrobe("t4 s1", base + 1, 16'h11BB);
    expStrobe("t4 s2", base + 2, 16'h12CC);
    base = weLog.size();
    i2cStart();
    sendByte(8'h34, -1, ack);
    sendByte(8'hFF, -1, ack);
    sendByte(8'h01, -1, ack);
    sendByte(8'h02, -1, ack);
    i2cStop();
    chk("t4 wrap n", weLog.size() - base, 2);
    expStrobe("t4 wrap s0", base, 16'hFF01);
    expStrobe("t4 wrap s1", base + 1, 16'h0002);

    // 5: STOP mid data byte, repeated START mid sub-address
    base = weLog.size();
    i2cStart();
    sendByte(8'h34, -1, ack);
    sendByte(8'h20, -1, ack);
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    i2cStop();
    chk("t5 busy stop", regIf.oBUSY, 1'b0);
    chk("t5 nstrobe partial", weLog.size() - base, 0);
    i2cStart();
    sendByte(8'h34, -1, ack);
    for (int i = 0; i < 4; i++) sendBit(1'b0);
    i2cStart();
    chk("t5 busy rstart", regIf.oBUSY, 1'b1);
    sendByte(8'h34, -1, ack); chk("t5 ack addr", ack, 1'b1);
    sendByte(8'h30, -1, ack);
    sendByte(8'h99, -1, ack); chk("t5 ack data", ack, 1'b1);
    i2cStop();
    chk("t5 nstrobe", weLog.size() - base, 1);
    expStrobe("t5 strobe", base, 16'h3099);

    // 6: reset during the data ACK drive, then SCL glitch rejection
    base = weLog.size();
    i2cStart();
    sendByte(8'h34, -1, ack);
    sendByte(8'h22, -1, ack);
    for (int i = 7; i >= 0; i--) sendBit(i[0] ? 1'b0 : 1'b1);
    sdaLow = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (sdaLine === 1'b0) seen = 1'b1;
      else wq(1);
    end
    chk("t6 ack driven", seen, 1'b1);
    chk("t6 pre nstrobe", weLog.size() - base, 1);
    expStrobe("t6 pre strobe", base, 16'h2255);
    rstN = 1'b0;
    #1;
    chk("t6 rst sda", sdaLine, 1'b1);
    chk("t6 rst addr", regIf.oREG_ADDR, 8'h00);
    chk("t6 rst data", regIf.oREG_DATA, 8'h00);
    chk("t6 rst we", regIf.oREG_WE, 1'b0);
    chk("t6 rst busy", regIf.oBUSY, 1'b0);
    wq(3);
    rstN = 1'b1;
    scl = 1'b1;
    wq(Q);
    chk("t6 idle busy", regIf.oBUSY, 1'b0);
    chk("t6 idle sda", sdaLine, 1'b1);
    i2cStart();
    sendByte(8'h34, 3, ack); chk("t6 glitch ack", ack, 1'b1);
    sendByte(8'h05, -1, ack);
    sendByte(8'h77, -1, ack); chk("t6 ack data", ack, 1'b1);
    i2cStop();
    chk("t6 nstrobe", weLog.size() - base, 2);
    expStrobe("t6 strobe", base + 1, 16'h0577);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
